clk_div_bank: RTL and testbench

- Parametrised, multi-channel successor to the fixed two-divider clock tree. It generates NUM_CH divided clocks from the bit-rate clock, and each channel has a runtime-programmable ratio.
- Ratio changes are glitch-free because new ratios are applied only at period boundaries.
- Adds per-channel single-cycle strobes, lock indication and a common phase-align input, so Bit_Rate_10 and PCLK style outputs can be edge-aligned.
- Sits directly after freq_mul and feeds the serializer and PCS clocking.

---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_chan.sv | 128 ++++++++++++
 rtl/clk_div_bank.sv | 37 +++
 tb/tb_clk_div_bank.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and channel state type for the clk_div_bank divider tree.
package clk_div_pkg;

  localparam int MIN_RATIO        = 2;
  localparam int DIV_W_DEF        = 8;
  localparam int LOCK_PERIODS_DEF = 2;
  localparam int LOCK_CNT_W       = 4;

  typedef enum logic {
    CH_RUN      = 1'b0,
    CH_DISABLED = 1'b1
  } ch_state_e;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, shadow/pending ratio, lock tracking and duty decode.
//   state       | meaning
//   CH_RUN      | counting at an active ratio >= 2, outputs toggle
//   CH_DISABLED | active ratio is 0 or 1; outputs held low until a valid ratio is pending
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W         = DIV_W_DEF,
  parameter int DEFAULT_RATIO = 10,
  parameter int LOCK_PERIODS  = LOCK_PERIODS_DEF
) (
  input  logic             Ref_Clk,
  input  logic             Rst,
  input  logic [DIV_W-1:0] ratio_i,
  input  logic             load_i,
  input  logic             align_i,
  output logic             div_clk_o,
  output logic             div_stb_o,
  output logic             locked_o
);

  localparam logic [DIV_W-1:0]      ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0]      MIN_R    = DIV_W'(MIN_RATIO);
  localparam logic [DIV_W-1:0]      DEF_R    = DIV_W'(DEFAULT_RATIO);
  localparam logic [LOCK_CNT_W-1:0] LOCK_MAX = LOCK_CNT_W'(LOCK_PERIODS);
  localparam logic [LOCK_CNT_W-1:0] LOCK_ONE = LOCK_CNT_W'(1);

  ch_state_e             state_q, state_d;
  logic [DIV_W-1:0]      ratio_q, ratio_d;
  logic [DIV_W-1:0]      shadow_q, shadow_d;
  logic [DIV_W-1:0]      cnt_q, cnt_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic                  pend_q, pend_d;
  logic                  prime_q, prime_d;
  logic                  clk_q, clk_d;
  logic                  stb_q, stb_d;
  logic                  locked_q, locked_d;
  logic                  wrap, shadow_ok, running;

  always_comb begin
    state_d    = state_q;
    ratio_d    = ratio_q;
    shadow_d   = shadow_q;
    cnt_d      = cnt_q;
    lock_cnt_d = lock_cnt_q;
    pend_d     = pend_q;
    prime_d    = prime_q;
    wrap       = (cnt_q == ratio_q - ONE);
    shadow_ok  = (shadow_q >= MIN_R);

    unique case (state_q)
      CH_RUN: begin
        if (align_i || wrap) begin
          cnt_d = '0;
          if (pend_q) begin
            ratio_d    = shadow_q;
            pend_d     = 1'b0;
            lock_cnt_d = '0;
            if (!shadow_ok) state_d = CH_DISABLED;
          end else if (align_i) begin
            lock_cnt_d = '0;
          end else if (prime_q && lock_cnt_q != LOCK_MAX) begin
            lock_cnt_d = lock_cnt_q + LOCK_ONE;
          end
          // The first wrap after reset or re-enable closes no real period.
          prime_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      CH_DISABLED: begin
        cnt_d      = '0;
        lock_cnt_d = '0;
        if (pend_q) begin
          ratio_d = shadow_q;
          pend_d  = 1'b0;
          if (shadow_ok) begin
            state_d = CH_RUN;
            cnt_d   = shadow_q - ONE;
            prime_d = 1'b0;
          end
        end
      end
      default: state_d = CH_DISABLED;
    endcase

    if (load_i) begin
      shadow_d = ratio_i;
      pend_d   = 1'b1;
    end

    running  = (state_d == CH_RUN);
    clk_d    = running && (cnt_d < ratio_d - (ratio_d >> 1));
    stb_d    = running && (cnt_d == '0);
    locked_d = running && (lock_cnt_d == LOCK_MAX);
  end

  always_ff @(posedge Ref_Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= CH_RUN;
      ratio_q    <= DEF_R;
      shadow_q   <= DEF_R;
      cnt_q      <= DEF_R - ONE;
      lock_cnt_q <= '0;
      pend_q     <= 1'b0;
      prime_q    <= 1'b0;
      clk_q      <= 1'b0;
      stb_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ratio_q    <= ratio_d;
      shadow_q   <= shadow_d;
      cnt_q      <= cnt_d;
      lock_cnt_q <= lock_cnt_d;
      pend_q     <= pend_d;
      prime_q    <= prime_d;
      clk_q      <= clk_d;
      stb_q      <= stb_d;
      locked_q   <= locked_d;
    end
  end

  assign div_clk_o = clk_q;
  assign div_stb_o = stb_q;
  assign locked_o  = locked_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers sharing a common phase-align pulse.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int DIV_W         = DIV_W_DEF,
  parameter int DEFAULT_RATIO = 10,
  parameter int LOCK_PERIODS  = LOCK_PERIODS_DEF
) (
  input  logic                    Ref_Clk,
  input  logic                    Rst,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  input  logic [NUM_CH-1:0]       ratio_load,
  input  logic                    align,
  output logic [NUM_CH-1:0]       div_clk,
  output logic [NUM_CH-1:0]       div_stb,
  output logic [NUM_CH-1:0]       locked
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_chan #(
      .DIV_W         (DIV_W),
      .DEFAULT_RATIO (DEFAULT_RATIO),
      .LOCK_PERIODS  (LOCK_PERIODS)
    ) u_chan (
      .Ref_Clk   (Ref_Clk),
      .Rst       (Rst),
      .ratio_i   (div_ratio[i*DIV_W +: DIV_W]),
      .load_i    (ratio_load[i]),
      .align_i   (align),
      .div_clk_o (div_clk[i]),
      .div_stb_o (div_stb[i]),
      .locked_o  (locked[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: edge-indexed vector table plus reset and back-to-back load sequences.
module tb_clk_div_bank;

  logic        Ref_Clk = 1'b0;
  logic        Rst;
  logic [15:0] div_ratio;
  logic [1:0]  ratio_load;
  logic        align;
  logic [1:0]  div_clk, div_stb, locked;

  int checks = 0;
  int errors = 0;

  clk_div_bank dut (
    .Ref_Clk    (Ref_Clk),
    .Rst        (Rst),
    .div_ratio  (div_ratio),
    .ratio_load (ratio_load),
    .align      (align),
    .div_clk    (div_clk),
    .div_stb    (div_stb),
    .locked     (locked)
  );

  always #5 Ref_Clk = ~Ref_Clk;

  typedef struct {
    int         adv;
    logic [1:0] load;
    logic [15:0] ratio;
    logic       aln;
    logic [1:0] e_clk;
    logic [1:0] e_stb;
    logic [1:0] e_lck;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int adv, input logic [1:0] load, input logic [15:0] ratio,
                     input logic aln, input logic [1:0] e_clk, input logic [1:0] e_stb,
                     input logic [1:0] e_lck);
    vec_t v;
    v.adv = adv; v.load = load; v.ratio = ratio; v.aln = aln;
    v.e_clk = e_clk; v.e_stb = e_stb; v.e_lck = e_lck;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge Ref_Clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %b expected %b", name, idx, act, exp);
    end
  endtask

  localparam logic [15:0] R_DEF = 16'h0A0A;  // {ch1, ch0}
  localparam logic [15:0] R_A   = 16'h140A;  // ch1=20 ch0=10
  localparam logic [15:0] R_B   = 16'h1405;  // ch0=5
  localparam logic [15:0] R_C   = 16'h1401;  // ch0=1
  localparam logic [15:0] R_D   = 16'h1404;  // ch0=4

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Edge numbers in comments count rising edges after reset release.
    add(1,  2'b00, R_DEF, 1'b0, 2'b11, 2'b11, 2'b00); // e1
    add(1,  2'b00, R_DEF, 1'b0, 2'b11, 2'b00, 2'b00); // e2
    add(3,  2'b00, R_DEF, 1'b0, 2'b11, 2'b00, 2'b00); // e5
    add(1,  2'b00, R_DEF, 1'b0, 2'b00, 2'b00, 2'b00); // e6
    add(4,  2'b00, R_DEF, 1'b0, 2'b00, 2'b00, 2'b00); // e10
    add(1,  2'b00, R_DEF, 1'b0, 2'b11, 2'b11, 2'b00); // e11
    add(9,  2'b00, R_DEF, 1'b0, 2'b00, 2'b00, 2'b00); // e20
    add(1,  2'b00, R_DEF, 1'b0, 2'b11, 2'b11, 2'b11); // e21 lock
    add(2,  2'b00, R_DEF, 1'b0, 2'b11, 2'b00, 2'b11); // e23
    add(1,  2'b10, R_A,   1'b0, 2'b11, 2'b00, 2'b11); // e24 load ch1=20
    add(6,  2'b00, R_A,   1'b0, 2'b00, 2'b00, 2'b11); // e30
    add(1,  2'b00, R_A,   1'b0, 2'b11, 2'b11, 2'b01); // e31 ch1 ratio applied
    add(4,  2'b00, R_A,   1'b0, 2'b11, 2'b00, 2'b01); // e35
    add(1,  2'b00, R_A,   1'b0, 2'b10, 2'b00, 2'b01); // e36
    add(4,  2'b00, R_A,   1'b0, 2'b10, 2'b00, 2'b01); // e40
    add(1,  2'b00, R_A,   1'b0, 2'b01, 2'b01, 2'b01); // e41
    add(9,  2'b00, R_A,   1'b0, 2'b00, 2'b00, 2'b01); // e50
    add(1,  2'b00, R_A,   1'b0, 2'b11, 2'b11, 2'b01); // e51
    add(19, 2'b00, R_A,   1'b0, 2'b00, 2'b00, 2'b01); // e70
    add(1,  2'b00, R_A,   1'b0, 2'b11, 2'b11, 2'b11); // e71 ch1 relock
    add(9,  2'b00, R_A,   1'b0, 2'b10, 2'b00, 2'b11); // e80
    add(1,  2'b01, R_B,   1'b0, 2'b01, 2'b01, 2'b11); // e81 load on wrap edge
    add(9,  2'b00, R_B,   1'b0, 2'b00, 2'b00, 2'b11); // e90
    add(1,  2'b00, R_B,   1'b0, 2'b11, 2'b11, 2'b10); // e91 ch0 ratio 5
    add(2,  2'b00, R_B,   1'b0, 2'b11, 2'b00, 2'b10); // e93
    add(1,  2'b00, R_B,   1'b0, 2'b10, 2'b00, 2'b10); // e94
    add(1,  2'b00, R_B,   1'b0, 2'b10, 2'b00, 2'b10); // e95
    add(1,  2'b00, R_B,   1'b0, 2'b11, 2'b01, 2'b10); // e96
    add(1,  2'b01, R_C,   1'b0, 2'b11, 2'b00, 2'b10); // e97 load ch0=1
    add(4,  2'b00, R_C,   1'b0, 2'b00, 2'b00, 2'b10); // e101 ch0 disabled
    add(4,  2'b00, R_C,   1'b0, 2'b00, 2'b00, 2'b10); // e105
    add(1,  2'b01, R_D,   1'b0, 2'b00, 2'b00, 2'b10); // e106 load ch0=4
    add(1,  2'b00, R_D,   1'b0, 2'b00, 2'b00, 2'b10); // e107 enable, cnt=R-1
    add(1,  2'b00, R_D,   1'b0, 2'b01, 2'b01, 2'b10); // e108
    add(1,  2'b00, R_D,   1'b0, 2'b01, 2'b00, 2'b10); // e109
    add(1,  2'b00, R_D,   1'b0, 2'b00, 2'b00, 2'b10); // e110
    add(1,  2'b00, R_D,   1'b0, 2'b10, 2'b10, 2'b10); // e111
    add(1,  2'b00, R_D,   1'b0, 2'b11, 2'b01, 2'b10); // e112
    add(1,  2'b01, R_A,   1'b0, 2'b11, 2'b00, 2'b10); // e113 load ch0=10
    add(1,  2'b00, R_A,   1'b1, 2'b11, 2'b11, 2'b00); // e114 align
    add(4,  2'b00, R_A,   1'b0, 2'b11, 2'b00, 2'b00); // e118
    add(1,  2'b00, R_A,   1'b0, 2'b10, 2'b00, 2'b00); // e119
    add(5,  2'b00, R_A,   1'b0, 2'b01, 2'b01, 2'b00); // e124
    add(10, 2'b00, R_A,   1'b0, 2'b11, 2'b11, 2'b01); // e134
    add(20, 2'b00, R_A,   1'b0, 2'b11, 2'b11, 2'b11); // e154

    Rst = 1'b1; div_ratio = R_DEF; ratio_load = 2'b00; align = 1'b0;
    tick(); tick();
    chk("rst_clk", 0, div_clk, 2'b00);
    chk("rst_stb", 0, div_stb, 2'b00);
    chk("rst_lck", 0, locked, 2'b00);
    Rst = 1'b0;

    foreach (vecs[i]) begin
      ratio_load = vecs[i].load;
      div_ratio  = vecs[i].ratio;
      align      = vecs[i].aln;
      tick();
      ratio_load = 2'b00;
      align      = 1'b0;
      for (int k = 1; k < vecs[i].adv; k++) tick();
      chk("vec_clk", i, div_clk, vecs[i].e_clk);
      chk("vec_stb", i, div_stb, vecs[i].e_stb);
      chk("vec_lck", i, locked, vecs[i].e_lck);
    end

    // Async reset mid-period with a ch1 ratio of 6 pending.
    div_ratio = 16'h060A; ratio_load = 2'b10;
    tick();
    ratio_load = 2'b00;
    #2;
    chk("pre_rst_clk", 200, div_clk, 2'b11);
    Rst = 1'b1;
    #1;
    chk("async_rst_clk", 201, div_clk, 2'b00);
    chk("async_rst_lck", 201, locked, 2'b00);
    tick(); tick();
    Rst = 1'b0;
    div_ratio = R_DEF;
    tick();                                   // e1
    chk("rerel_stb", 202, div_stb, 2'b11);
    chk("rerel_clk", 202, div_clk, 2'b11);
    for (int k = 0; k < 6; k++) tick();       // e7
    chk("discard_stb", 203, div_stb, 2'b00);
    chk("discard_clk", 203, div_clk, 2'b00);
    for (int k = 0; k < 4; k++) tick();       // e11
    chk("default_stb", 204, div_stb, 2'b11);

    // Back-to-back loads on ch0: 4 then 6; 6 must take effect.
    div_ratio = 16'h0A04; ratio_load = 2'b01;
    tick();                                   // e12
    div_ratio = 16'h0A06;
    tick();                                   // e13
    ratio_load = 2'b00;
    for (int k = 0; k < 8; k++) tick();       // e21
    chk("b2b_apply_stb", 205, div_stb, 2'b11);
    chk("b2b_apply_lck", 205, locked, 2'b10);
    for (int k = 0; k < 4; k++) tick();       // e25
    chk("b2b_not4_stb", 206, div_stb, 2'b00);
    tick(); tick();                           // e27
    chk("b2b_is6_stb", 207, div_stb, 2'b01);
    chk("b2b_is6_clk", 207, div_clk, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
